// File: rtl/pwm_duty_meas_if.sv
// Signal bundle between a PWM duty/period measurement block and its consumer.
// The consumer (master) drives enable and the raw PWM line; the meter (slave) returns results.
interface pwm_duty_meas_if;
  logic        en;
  logic        PWM_in;
  logic [10:0] duty;
  logic [11:0] period;
  logic        duty_vld;
  logic        stuck_hi;
  logic        stuck_lo;

  modport master (
    output en,
    output PWM_in,
    input  duty,
    input  period,
    input  duty_vld,
    input  stuck_hi,
    input  stuck_lo
  );

  modport slave (
    input  en,
    input  PWM_in,
    output duty,
    output period,
    output duty_vld,
    output stuck_hi,
    output stuck_lo
  );
endinterface

// File: rtl/pwm_duty_meas.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in clk cycles,
// reporting on a one-cycle strobe and flagging inputs stuck high or low.
module pwm_duty_meas #(
  parameter int unsigned TIMEOUT = 4095  // at most 4095: the edge timer is 12 bits
) (
  input logic             clk,
  input logic             rst_n,
  pwm_duty_meas_if.slave  bus
);

  localparam logic [11:0] TmrLimit = 12'(TIMEOUT);
  localparam logic [11:0] CntMax   = 12'hfff;
  localparam logic [10:0] DutyMax  = 11'h7ff;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StHigh,
    StLow
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [11:0] hi_cnt_q, hi_cnt_d;
  logic [11:0] per_cnt_q, per_cnt_d;
  logic [11:0] tmr_q, tmr_d;
  logic [10:0] duty_q, duty_d;
  logic [11:0] period_q, period_d;
  logic        vld_q, vld_d;
  logic        stuck_hi_q, stuck_hi_d;
  logic        stuck_lo_q, stuck_lo_d;

  logic rise, fall, edge_seen, timeout;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CntMax) ? v : v + 12'd1;
  endfunction

  // Both edges come from the same s2/s3 pair, so rise and fall see identical latency.
  assign rise      = s2_q & ~s3_q;
  assign fall      = ~s2_q & s3_q;
  assign edge_seen = rise | fall;
  assign timeout   = (tmr_q == TmrLimit) && !edge_seen;

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    per_cnt_d  = per_cnt_q;
    tmr_d      = tmr_q;
    duty_d     = duty_q;
    period_d   = period_q;
    vld_d      = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;

    if (!bus.en) begin
      state_d   = StIdle;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      tmr_d     = '0;
    end else if (state_q == StIdle) begin
      state_d   = StSync;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      tmr_d     = '0;
    end else begin
      tmr_d = edge_seen ? '0 : tmr_q + 12'd1;

      case (state_q)
        StSync: begin
          // First rise only opens a full period; anything before it is partial.
          if (rise) begin
            state_d   = StHigh;
            hi_cnt_d  = 12'd1;
            per_cnt_d = 12'd1;
          end
        end
        StHigh: begin
          per_cnt_d = sat_inc(per_cnt_q);
          if (fall) begin
            state_d = StLow;
          end else begin
            hi_cnt_d = sat_inc(hi_cnt_q);
          end
        end
        StLow: begin
          if (rise) begin
            duty_d     = hi_cnt_q[11] ? DutyMax : hi_cnt_q[10:0];
            period_d   = per_cnt_q;
            vld_d      = 1'b1;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
            state_d    = StHigh;
            hi_cnt_d   = 12'd1;
            per_cnt_d  = 12'd1;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (timeout) begin
        duty_d     = s2_q ? DutyMax : '0;
        period_d   = CntMax;
        vld_d      = 1'b1;
        stuck_hi_d = s2_q;
        stuck_lo_d = ~s2_q;
        state_d    = StSync;
        tmr_d      = '0;
        hi_cnt_d   = '0;
        per_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      tmr_q      <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= bus.PWM_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      hi_cnt_q   <= hi_cnt_d;
      per_cnt_q  <= per_cnt_d;
      tmr_q      <= tmr_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign bus.duty     = duty_q;
  assign bus.period   = period_q;
  assign bus.duty_vld = vld_q;
  assign bus.stuck_hi = stuck_hi_q;
  assign bus.stuck_lo = stuck_lo_q;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Bench for pwm_duty_meas: PWM frame generator, timestamp-based reference model,
// per-cycle output comparison and a few literal expectations.
module tb_pwm_duty_meas;

  localparam int unsigned TIMEOUT = 4095;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  pwm_duty_meas_if bus ();

  pwm_duty_meas #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vld_total = 0;
  bit cmp_on = 1'b0;

  // Reference model: remembers edge timestamps instead of running counters.
  longint cyc = 0;
  longint t_rise = 0, t_fall = 0, t_ref = 0;
  bit m_s1 = 0, m_s2 = 0, m_s3 = 0;
  bit active = 0, armed = 0, in_high = 0;
  int m_duty = 0, m_period = 0;
  bit m_vld = 0, m_hi = 0, m_lo = 0;

  always @(posedge clk or negedge rst_n) begin
    bit rise, fall, lvl;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      active = 0; armed = 0; in_high = 0;
      m_duty = 0; m_period = 0; m_vld = 0; m_hi = 0; m_lo = 0;
    end else begin
      cyc++;
      rise = m_s2 && !m_s3;
      fall = !m_s2 && m_s3;
      lvl  = m_s2;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.PWM_in;
      m_vld = 0;
      if (!bus.en) begin
        active = 0; armed = 0; in_high = 0;
      end else if (!active) begin
        active = 1; armed = 0; in_high = 0;
        t_ref = cyc + 1;
      end else if (rise || fall) begin
        t_ref = cyc + 1;
        if (rise) begin
          if (armed && !in_high) begin
            m_vld    = 1;
            m_duty   = (t_fall - t_rise > 2047) ? 2047 : int'(t_fall - t_rise);
            m_period = (cyc - t_rise > 4095) ? 4095 : int'(cyc - t_rise);
            m_hi = 0; m_lo = 0;
          end
          armed = 1; in_high = 1; t_rise = cyc;
        end else if (armed && in_high) begin
          in_high = 0; t_fall = cyc;
        end
      end else if (cyc - t_ref == longint'(TIMEOUT)) begin
        m_vld = 1;
        m_hi = lvl; m_lo = !lvl;
        m_duty = lvl ? 2047 : 0;
        m_period = 4095;
        armed = 0; in_high = 0;
        t_ref = cyc + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_loop();
    logic [25:0] got, want;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        got  = {bus.duty, bus.period, bus.duty_vld, bus.stuck_hi, bus.stuck_lo};
        want = {11'(m_duty), 12'(m_period), m_vld, m_hi, m_lo};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL cycle_compare t=%0t: got duty=%0d per=%0d vld=%b hi=%b lo=%b, expected duty=%0d per=%0d vld=%b hi=%b lo=%b",
                   $time, got[25:15], got[14:3], got[2], got[1], got[0],
                   m_duty, m_period, m_vld, m_hi, m_lo);
        end
        if (bus.duty_vld === 1'b1) vld_total++;
      end
    end
  endtask

  // PWM generator: high for the first gen_d cycles of every gen_p-cycle frame.
  int gen_p = 2048, gen_d = 0, gen_ph = 0;

  task automatic set_gen(input int p, input int d);
    gen_p = p; gen_d = d; gen_ph = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      bus.PWM_in = (gen_ph < gen_d);
      @(posedge clk);
      #1;
      gen_ph = (gen_ph + 1) % gen_p;
    end
  endtask

  task automatic check_out(input string name, input int duty, input int period,
                           input int hi, input int lo);
    check({name, "_duty"}, int'(bus.duty), duty);
    check({name, "_period"}, int'(bus.period), period);
    check({name, "_stuck_hi"}, int'(bus.stuck_hi), hi);
    check({name, "_stuck_lo"}, int'(bus.stuck_lo), lo);
  endtask

  initial begin
    int base, p, d, n;
    bus.en = 1'b0;
    bus.PWM_in = 1'b0;
    fork
      cmp_loop();
    join_none
    #1 rst_n = 1'b0;
    #1 cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0);
    check("reset_vld", int'(bus.duty_vld), 0);
    rst_n = 1'b1;
    bus.en = 1'b1;

    // Nominal 50% duty; nothing may be reported before the second rise.
    set_gen(2048, 1024);
    base = vld_total;
    step(2048);
    check("d1024_no_early_report", vld_total - base, 0);
    step(4096);
    check("d1024_report_count", vld_total - base, 2);
    check_out("d1024", 1024, 2048, 0, 0);
    check("model_pin_duty1024", m_duty, 1024);

    // Extreme duties: a single-cycle low, then a single-cycle high.
    set_gen(2048, 2047);
    step(4096);
    check_out("d2047", 2047, 2048, 0, 0);
    set_gen(2048, 1);
    step(4096);
    check_out("d1", 1, 2048, 0, 0);
    check("model_pin_duty1", m_duty, 1);

    // Line held low long enough for two timeout reports.
    set_gen(2048, 0);
    base = vld_total;
    step(9000);
    check("stuck_lo_count", vld_total - base, 2);
    check_out("stuck_lo", 0, 4095, 0, 1);
    check("model_pin_period4095", m_period, 4095);
    set_gen(2048, 600);
    step(6144);
    check_out("d600", 600, 2048, 0, 0);

    // Line forced high: one normal report at the rise, then two stuck-high reports.
    set_gen(2048, 2048);
    base = vld_total;
    step(10000);
    check("stuck_hi_count", vld_total - base, 3);
    check_out("stuck_hi", 2047, 4095, 1, 0);
    set_gen(2048, 300);
    step(6144);
    check_out("d300", 300, 2048, 0, 0);

    // Enable dropped mid-high: outputs hold, no strobes; restart needs two rises.
    set_gen(2048, 800);
    step(2 * 2048 + 400);
    check_out("d800_pre", 800, 2048, 0, 0);
    bus.en = 1'b0;
    base = vld_total;
    step(3000);
    check("en_off_no_report", vld_total - base, 0);
    check_out("en_off_hold", 800, 2048, 0, 0);
    bus.en = 1'b1;
    base = vld_total;
    step(1696);
    check("reenable_first_rise_silent", vld_total - base, 0);
    step(2048);
    check("reenable_second_rise", vld_total - base, 1);
    check_out("d800_post", 800, 2048, 0, 0);

    // Asynchronous reset in the low phase clears outputs without waiting for a clock.
    set_gen(2048, 1500);
    step(1800);
    rst_n = 1'b0;
    #2;
    check_out("reset_mid_low", 0, 0, 0, 0);
    check("reset_mid_low_vld", int'(bus.duty_vld), 0);
    step(3);
    rst_n = 1'b1;
    base = vld_total;
    step(6144);
    check("post_reset_count", vld_total - base, 2);
    check_out("d1500", 1500, 2048, 0, 0);

    // Randomised frames and enable glitches, checked cycle by cycle against the model.
    for (int seg = 0; seg < 6; seg++) begin
      p = $urandom_range(500, 8);
      d = $urandom_range(p, 0);
      n = 4 * p + $urandom_range(200, 0);
      set_gen(p, d);
      if ($urandom_range(2, 0) == 0) begin
        step(n / 2);
        bus.en = 1'b0;
        step($urandom_range(40, 1));
        bus.en = 1'b1;
        step(n - n / 2);
      end else begin
        step(n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
